// File: rtl/operand_aligner.sv
// rtl/operand_aligner.sv - FP add/sub front end: unpack, magnitude order, iterative mantissa alignment
module operand_aligner #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [26:0]      big_mant,
   output logic [26:0]      small_mant,
   output logic [7:0]       exp_result,
   output logic             result_sign,
   output logic             op,
   output logic             special
);

   localparam logic [4:0] STEP_W  = 5'(STEP);
   localparam logic [7:0] MAX_SHF = 8'd27;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d, b_q, b_d;
   logic        sub_q, sub_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [26:0] big_mant_q, big_mant_d;
   logic [26:0] small_mant_q, small_mant_d;
   logic [7:0]  exp_result_q, exp_result_d;
   logic        result_sign_q, result_sign_d;
   logic        op_q, op_d;
   logic        special_q, special_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;

   // Unpack of the latched operands
   logic [7:0]  exp_a, exp_b, eff_a, eff_b, diff;
   logic        hid_a, hid_b, sign_a, sign_b, a_big, mag_eq, eff_op;
   logic [31:0] mag_a, mag_b;
   logic [26:0] mant_a, mant_b;
   logic [4:0]  cnt_u;

   always_comb begin
      exp_a  = a_q[30:23];
      exp_b  = b_q[30:23];
      hid_a  = |exp_a;
      hid_b  = |exp_b;
      eff_a  = hid_a ? exp_a : 8'd1;
      eff_b  = hid_b ? exp_b : 8'd1;
      mag_a  = {eff_a, hid_a, a_q[22:0]};
      mag_b  = {eff_b, hid_b, b_q[22:0]};
      mant_a = {hid_a, a_q[22:0], 3'b000};
      mant_b = {hid_b, b_q[22:0], 3'b000};
      sign_a = a_q[31];
      sign_b = b_q[31] ^ sub_q;
      a_big  = (mag_a >= mag_b);
      mag_eq = (mag_a == mag_b);
      eff_op = ~(sign_a ^ sign_b);
      diff   = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
      cnt_u  = (diff > MAX_SHF) ? MAX_SHF[4:0] : diff[4:0];
   end

   // One alignment step: shift by k and fold the lost bits into the sticky bit
   logic [4:0]  shift_k;
   logic [26:0] lost_mask, shifted;

   always_comb begin
      shift_k   = (cnt_q < STEP_W) ? cnt_q : STEP_W;
      lost_mask = (27'd1 << shift_k) - 27'd1;
      shifted   = (small_mant_q >> shift_k) | {26'b0, |(small_mant_q & lost_mask)};
   end

   always_comb begin
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      sub_d         = sub_q;
      cnt_d         = cnt_q;
      big_mant_d    = big_mant_q;
      small_mant_d  = small_mant_q;
      exp_result_d  = exp_result_q;
      result_sign_d = result_sign_q;
      op_d          = op_q;
      special_d     = special_q;
      in_ready_d    = in_ready_q;
      out_valid_d   = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               sub_d      = sub;
               in_ready_d = 1'b0;
               state_d    = S_UNPACK;
            end
         end
         S_UNPACK: begin
            big_mant_d    = a_big ? mant_a : mant_b;
            small_mant_d  = a_big ? mant_b : mant_a;
            exp_result_d  = a_big ? eff_a : eff_b;
            op_d          = eff_op;
            // Exact cancellation always yields +0
            result_sign_d = (!eff_op && mag_eq) ? 1'b0 : (a_big ? sign_a : sign_b);
            special_d     = (exp_a == 8'hFF) || (exp_b == 8'hFF);
            cnt_d         = cnt_u;
            if (cnt_u == 5'd0) begin
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            small_mant_d = shifted;
            cnt_d        = cnt_q - shift_k;
            if (cnt_q == shift_k) begin
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         a_q           <= '0;
         b_q           <= '0;
         sub_q         <= 1'b0;
         cnt_q         <= '0;
         big_mant_q    <= '0;
         small_mant_q  <= '0;
         exp_result_q  <= '0;
         result_sign_q <= 1'b0;
         op_q          <= 1'b0;
         special_q     <= 1'b0;
         in_ready_q    <= 1'b1;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         sub_q         <= sub_d;
         cnt_q         <= cnt_d;
         big_mant_q    <= big_mant_d;
         small_mant_q  <= small_mant_d;
         exp_result_q  <= exp_result_d;
         result_sign_q <= result_sign_d;
         op_q          <= op_d;
         special_q     <= special_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign big_mant    = big_mant_q;
   assign small_mant  = small_mant_q;
   assign exp_result  = exp_result_q;
   assign result_sign = result_sign_q;
   assign op          = op_q;
   assign special     = special_q;

endmodule

// File: tb/tb_operand_aligner.sv
// tb/tb_operand_aligner.sv - randomized self-checking bench for operand_aligner
module tb_operand_aligner;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [26:0] big_mant, small_mant;
   logic [7:0]  exp_result;
   logic        result_sign, op, special;

   int total = 0;
   int bad   = 0;

   operand_aligner #(.WIDTH(32), .STEP(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .big_mant(big_mant), .small_mant(small_mant), .exp_result(exp_result),
      .result_sign(result_sign), .op(op), .special(special)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected results from the arithmetic definition of the operation
   logic [26:0] e_big, e_small;
   logic [7:0]  e_exp;
   logic        e_sign, e_op, e_special;
   int          e_lat;

   task automatic model(input logic [31:0] ma_in, input logic [31:0] mb_in, input logic s);
      int     ea, eb, ebig, esml, sh;
      longint ma, mb, mag_a, mag_b, msml, lost;
      bit     sa, sb, ha, hb, abig;
      ha    = (ma_in[30:23] != 0);
      hb    = (mb_in[30:23] != 0);
      ea    = ha ? int'(ma_in[30:23]) : 1;
      eb    = hb ? int'(mb_in[30:23]) : 1;
      ma    = (longint'(ha) << 26) + (longint'(ma_in[22:0]) << 3);
      mb    = (longint'(hb) << 26) + (longint'(mb_in[22:0]) << 3);
      mag_a = longint'(ea) * 64'd134217728 + ma;
      mag_b = longint'(eb) * 64'd134217728 + mb;
      sa    = ma_in[31];
      sb    = mb_in[31] ^ s;
      abig  = (mag_a >= mag_b);
      ebig  = abig ? ea : eb;
      esml  = abig ? eb : ea;
      msml  = abig ? mb : ma;
      sh    = (ebig - esml > 27) ? 27 : ebig - esml;
      lost  = msml & ((64'd1 << sh) - 1);
      e_big     = 27'(abig ? ma : mb);
      e_small   = 27'((msml >> sh) | ((lost != 0) ? 64'd1 : 64'd0));
      e_exp     = 8'(ebig);
      e_op      = (sa == sb);
      e_sign    = (!e_op && mag_a == mag_b) ? 1'b0 : (abig ? sa : sb);
      e_special = (ma_in[30:23] == 8'hFF) || (mb_in[30:23] == 8'hFF);
      e_lat     = 2 + sh;
   endtask

   // Runs one operation; hold = cycles to stall out_ready while in DONE
   task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic is, input int hold);
      int lat;
      logic [26:0] hb_big, hb_small;
      model(ia, ib, is);
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      in_valid = 1'b1; a = ia; b = ib; sub = is;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(e_lat));
      chk("big_mant", 32'(big_mant), 32'(e_big));
      chk("small_mant", 32'(small_mant), 32'(e_small));
      chk("exp_result", 32'(exp_result), 32'(e_exp));
      chk("result_sign", 32'(result_sign), 32'(e_sign));
      chk("op", 32'(op), 32'(e_op));
      chk("special", 32'(special), 32'(e_special));
      hb_big   = big_mant;
      hb_small = small_mant;
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 3);
         a = $urandom; b = $urandom; sub = 1'b1;
         @(posedge clk); #1;
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_small", 32'(small_mant), 32'(hb_small));
         chk("hold_big", 32'(big_mant), 32'(hb_big));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_valid", 32'(out_valid), 32'd0);
      chk("post_in_ready", 32'(in_ready), 32'd1);
   endtask

   logic [31:0] ra, rb;
   int          stale;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_big", 32'(big_mant), 32'd0);
      chk("rst_small", 32'(small_mant), 32'd0);
      chk("rst_exp", 32'(exp_result), 32'd0);

      // Directed vectors, with fixed expectations alongside the model's
      run_op(32'h3F800000, 32'h40000000, 1'b0, 0);
      chk("t1_small", 32'(e_small), 32'h2000000);
      run_op(32'h4B800000, 32'h3F800000, 1'b0, 0);
      chk("t2a_lat", 32'(e_lat), 32'd26);
      run_op(32'h4F800000, 32'h3F800000, 1'b0, 0);
      chk("t2b_small", 32'(e_small), 32'h1);
      run_op(32'h40400000, 32'h40400000, 1'b1, 0);
      chk("t3_big", 32'(e_big), 32'h6000000);
      run_op(32'hC0000000, 32'h3F800000, 1'b1, 10);
      chk("t4_sign", 32'(e_sign), 32'd1);
      run_op(32'h00000001, 32'h00400000, 1'b0, 0);
      run_op(32'h7F800000, 32'h3F800000, 1'b1, 0);

      // Reset in the middle of a long alignment
      in_valid = 1'b1; a = 32'h4B800000; b = 32'h3F800000; sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_big", 32'(big_mant), 32'd0);
      chk("mid_rst_small", 32'(small_mant), 32'd0);
      stale = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("no_stale", 32'(stale), 32'd0);

      // Randomized operands: half fully random, half with nearby exponents
      for (int n = 0; n < 60; n++) begin
         ra = $urandom;
         rb = $urandom;
         if (n % 2 == 0) begin
            rb[30:23] = 8'(int'(ra[30:23]) + $urandom_range(0, 12) - 6);
            if ($urandom_range(0, 7) == 0) rb[22:0] = ra[22:0];
         end
         if ($urandom_range(0, 9) == 0) ra[30:23] = 8'h00;
         run_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
